// File: rtl/led_pattern_ctrl_pkg.sv
// led_pattern_pkg: shared key codes, mode encoding and speed limit for the
// LED pattern controller. Optional build macro used by the top: SPEED_WRAP_EN.
package led_pattern_pkg;

   // Scanner event codes; anything else on key_value is ignored
   localparam logic [3:0] KEY_S1   = 4'b0001;
   localparam logic [3:0] KEY_S2   = 4'b0010;
   localparam logic [3:0] KEY_S3   = 4'b0100;
   localparam logic [3:0] KEY_S4   = 4'b1000;
   localparam logic [3:0] KEY_NONE = 4'b1111;

   // Animation modes, S1 walks through them in encoding order
   typedef enum logic [1:0] {
      RUN_L  = 2'd0,
      RUN_R  = 2'd1,
      BOUNCE = 2'd2,
      BLINK  = 2'd3
   } mode_t;

   localparam logic [1:0] SPEED_MAX = 2'd3;

   // Next mode in the S1 cycle; BLINK wraps back to RUN_L
   function automatic mode_t next_mode(input mode_t m);
      return mode_t'(m + 2'd1);
   endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: key event input and LED drive output of the pattern
// controller. The master side (scanner/bench) drives key_value.
interface led_pattern_ctrl_if;
   logic [3:0] key_value;
   logic [7:0] led;

   modport master (output key_value, input led);
   modport slave  (input key_value, output led);
endinterface

// File: rtl/led_pattern_ctrl_step_timer.sv
// led_step_timer: free-running tick counter that issues a one-clock step
// pulse every 'period' enabled clocks. A clear restarts the count at 0 and
// suppresses any step due in that clock.
module led_step_timer #(
   parameter int CNT_W = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] period,
   input  logic             enable,
   input  logic             clear,
   output logic             step
);

   logic [CNT_W-1:0] cnt_reg;
   logic             at_end;

   // '>=' keeps the counter bounded even if the period shrinks mid-count
   assign at_end = (cnt_reg >= (period - CNT_W'(1)));
   assign step   = enable & ~clear & at_end;

   // Count 0..period-1 while enabled, wrap on the last value, restart on clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (clear) begin
         cnt_reg <= '0;
      end else if (enable) begin
         if (at_end)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: turns scanner key events into an animated pattern on 8
// active-low LEDs. S1 cycles mode, S2/S3 change speed, S4 toggles pause.
// Optional macro SPEED_WRAP_EN: speed wraps 3->0 / 0->3 instead of saturating.
module led_pattern_ctrl
   import led_pattern_pkg::*;
#(
   parameter int STEP_BASE = 5_000_000,
   parameter int CNT_W     = 23
) (
   input  logic               clk,
   input  logic               rst,
   led_pattern_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] BASE = CNT_W'(STEP_BASE);

   mode_t       mode_reg;
   logic [1:0]  speed_reg;
   logic        paused_reg;
   logic [2:0]  pos_reg;
   logic        dir_down_reg;
   logic        phase_reg;
   logic [7:0]  led_reg;

   logic        key_s1, key_s2, key_s3, key_s4, key_hit;
   logic [1:0]  speed_up_next, speed_dn_next;
   logic [CNT_W-1:0] period;
   logic        step_raw, step_apply;
   logic [7:0]  run_led;
   logic [7:0]  led_next;

   assign key_s1  = (bus.key_value == KEY_S1);
   assign key_s2  = (bus.key_value == KEY_S2);
   assign key_s3  = (bus.key_value == KEY_S3);
   assign key_s4  = (bus.key_value == KEY_S4);
   assign key_hit = key_s1 | key_s2 | key_s3 | key_s4;

`ifdef SPEED_WRAP_EN
   assign speed_up_next = speed_reg + 2'd1;
   assign speed_dn_next = speed_reg - 2'd1;
`else
   assign speed_up_next = (speed_reg == SPEED_MAX) ? speed_reg : speed_reg + 2'd1;
   assign speed_dn_next = (speed_reg == 2'd0)      ? speed_reg : speed_reg - 2'd1;
`endif

   assign period = BASE >> speed_reg;

   led_step_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .period (period),
      .enable (~paused_reg),
      .clear  (key_s1 | key_s2 | key_s3),
      .step   (step_raw)
   );

   // A key event in the same clock as a step wins; the step is dropped
   assign step_apply = step_raw & ~key_hit;

   // Control state: mode, speed and pause flag driven by key events
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_reg   <= RUN_L;
         speed_reg  <= 2'd0;
         paused_reg <= 1'b0;
      end else begin
         if (key_s1) mode_reg   <= next_mode(mode_reg);
         if (key_s2) speed_reg  <= speed_up_next;
         if (key_s3) speed_reg  <= speed_dn_next;
         if (key_s4) paused_reg <= ~paused_reg;
      end
   end

   // Pattern state: S1 restarts the animation, steps advance it per mode
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos_reg      <= 3'd0;
         dir_down_reg <= 1'b0;
         phase_reg    <= 1'b0;
      end else if (key_s1) begin
         pos_reg      <= 3'd0;
         dir_down_reg <= 1'b0;
         phase_reg    <= 1'b0;
      end else if (step_apply) begin
         unique case (mode_reg)
            RUN_L:  pos_reg <= pos_reg + 3'd1;
            RUN_R:  pos_reg <= pos_reg - 3'd1;
            BOUNCE: begin
               // Turn around on arrival at an end so each end is shown once
               if (dir_down_reg) begin
                  pos_reg <= pos_reg - 3'd1;
                  if (pos_reg == 3'd1) dir_down_reg <= 1'b0;
               end else begin
                  pos_reg <= pos_reg + 3'd1;
                  if (pos_reg == 3'd6) dir_down_reg <= 1'b1;
               end
            end
            BLINK:  phase_reg <= ~phase_reg;
            default: ;
         endcase
      end
   end

   // One-cold decode of the current position for the running modes
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_run_led
         assign run_led[gi] = (pos_reg != 3'(gi));
      end
   endgenerate

   assign led_next = (mode_reg == BLINK) ? {8{~phase_reg}} : run_led;

   // Registered LED drive, one clock behind the pattern state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         led_reg <= 8'hFF;
      else
         led_reg <= led_next;
   end

   assign bus.led = led_reg;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with STEP_BASE=16. A step-count
// reference model derives the expected LEDs every clock; directed tables and
// sequences pin down hand-computed values at the interesting clocks.
// Honours SPEED_WRAP_EN when the design is built with it.
module tb_led_pattern_ctrl;
   import led_pattern_pkg::*;

   localparam int STEP_BASE = 16;
   localparam int CNT_W     = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   led_pattern_ctrl_if bus_if ();

   led_pattern_ctrl #(
      .STEP_BASE (STEP_BASE),
      .CNT_W     (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: pattern is a function of mode and number of steps
   // taken since the last S1; clocks since the last restart give the steps.
   int m_mode, m_speed, m_paused, m_steps, m_elapsed;

   function automatic void model_reset();
      m_mode = 0; m_speed = 0; m_paused = 0; m_steps = 0; m_elapsed = 0;
   endfunction

   function automatic logic [7:0] model_led();
      logic [7:0] one;
      int p, t;
      one = 8'b1;
      case (m_mode)
         0: p = m_steps % 8;
         1: p = (8 - (m_steps % 8)) % 8;
         2: begin
            t = m_steps % 14;
            p = (t <= 7) ? t : 14 - t;
         end
         default: return (m_steps % 2 == 1) ? 8'h00 : 8'hFF;
      endcase
      return ~(one << p);
   endfunction

   // One unpaused clock; returns 1 when a full period has elapsed
   function automatic bit model_tick();
      m_elapsed++;
      if (m_elapsed == (STEP_BASE >> m_speed)) begin
         m_elapsed = 0;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_clock(input logic [3:0] key);
      bit s;
      case (key)
         KEY_S1: begin
            m_mode = (m_mode + 1) % 4; m_steps = 0; m_elapsed = 0;
         end
         KEY_S2: begin
`ifdef SPEED_WRAP_EN
            m_speed = (m_speed + 1) % 4;
`else
            if (m_speed < 3) m_speed++;
`endif
            m_elapsed = 0;
         end
         KEY_S3: begin
`ifdef SPEED_WRAP_EN
            m_speed = (m_speed + 3) % 4;
`else
            if (m_speed > 0) m_speed--;
`endif
            m_elapsed = 0;
         end
         KEY_S4: begin
            if (m_paused == 0) s = model_tick();   // counter runs, step dropped
            m_paused = 1 - m_paused;
         end
         default: begin
            if (m_paused == 0 && model_tick()) m_steps++;
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: led=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock with 'key' presented; LEDs compared with the model after the edge
   task automatic cycle(input logic [3:0] key);
      logic [7:0] exp;
      bus_if.key_value = key;
      @(posedge clk);
      if (rst) begin
         exp = model_led();
         model_clock(key);
      end else begin
         exp = 8'hFF;
      end
      #1;
      check("model", bus_if.led, exp);
      bus_if.key_value = KEY_NONE;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(KEY_NONE);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check("async_reset", bus_if.led, 8'hFF);
      idle(2);
      rst = 1'b1;
   endtask

   typedef struct {
      logic [3:0] key;
      int         cycles;
      logic [7:0] exp_led;
   } vec_t;

   vec_t vecs[12];
   int   bounce_exp[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
   logic [3:0] rand_keys[6] = '{KEY_S1, KEY_S2, KEY_S3, KEY_S4, 4'b0011, 4'b0000};

   initial begin
      logic [7:0] one;
      logic [3:0] k;
      one = 8'b1;
      bus_if.key_value = KEY_NONE;
      model_reset();

      // RUN_L from reset, S1 into RUN_R, invalid codes leave the count alone
      vecs[0]  = '{KEY_NONE, 1,   8'hFE};
      vecs[1]  = '{KEY_NONE, 15,  8'hFE};
      vecs[2]  = '{KEY_NONE, 1,   8'hFD};
      vecs[3]  = '{KEY_NONE, 110, 8'h7F};
      vecs[4]  = '{KEY_NONE, 2,   8'hFE};
      vecs[5]  = '{KEY_S1,   1,   8'hFE};
      vecs[6]  = '{KEY_NONE, 16,  8'hFE};
      vecs[7]  = '{KEY_NONE, 1,   8'h7F};
      vecs[8]  = '{4'b0011,  1,   8'h7F};
      vecs[9]  = '{4'b0000,  1,   8'h7F};
      vecs[10] = '{KEY_NONE, 13,  8'h7F};
      vecs[11] = '{KEY_NONE, 1,   8'hBF};

      #2;
      apply_reset();
      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].key);
         idle(vecs[i].cycles - 1);
         check($sformatf("vec%0d", i), bus_if.led, vecs[i].exp_led);
      end

      // BOUNCE: 16 steps trace the triangle, then async reset mid-animation
      apply_reset();
      cycle(KEY_S1);
      cycle(KEY_S1);
      for (int i = 0; i < 16; i++) begin
         idle(i == 0 ? 17 : 16);
         check($sformatf("bounce%0d", i), bus_if.led, ~(one << bounce_exp[i]));
      end
      apply_reset();
      idle(1);
      check("post_reset", bus_if.led, 8'hFE);

      // Speed keys
      apply_reset();
      repeat (4) cycle(KEY_S2);
`ifdef SPEED_WRAP_EN
      idle(16); check("wrap_s0_hold", bus_if.led, 8'hFE);
      idle(1);  check("wrap_s0_step", bus_if.led, 8'hFD);
      cycle(KEY_S3);
      idle(2);  check("wrap_s3_hold", bus_if.led, 8'hFD);
      idle(1);  check("wrap_s3_step", bus_if.led, 8'hFB);
`else
      idle(2);  check("fast_hold", bus_if.led, 8'hFE);
      idle(1);  check("fast_step1", bus_if.led, 8'hFD);
      idle(2);  check("fast_step2", bus_if.led, 8'hFB);
      repeat (5) cycle(KEY_S3);
      idle(16); check("slow_hold", bus_if.led, 8'hFB);
      idle(1);  check("slow_step", bus_if.led, 8'hF7);
`endif

      // Key on the same clock as a step: step dropped, count restarts
      apply_reset();
      idle(15);
      cycle(KEY_S2);
      idle(1);  check("collide_drop", bus_if.led, 8'hFE);
      idle(7);  check("collide_hold", bus_if.led, 8'hFE);
      idle(1);  check("collide_step", bus_if.led, 8'hFD);

      // Pause in BLINK
      apply_reset();
      repeat (3) cycle(KEY_S1);
      idle(1);  check("blink_off", bus_if.led, 8'hFF);
      idle(15); check("blink_hold", bus_if.led, 8'hFF);
      idle(1);  check("blink_on", bus_if.led, 8'h00);
      cycle(KEY_S4);
      idle(100); check("paused", bus_if.led, 8'h00);
      cycle(KEY_S4);
      idle(13); check("resume_hold", bus_if.led, 8'h00);
      idle(1);  check("resume_edge", bus_if.led, 8'h00);
      idle(1);  check("resume_step", bus_if.led, 8'hFF);
      idle(16); check("resume_next", bus_if.led, 8'h00);

      // Randomized key traffic against the model
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) != 0) begin
            k = KEY_NONE;
         end else if ($urandom_range(0, 6) == 6) begin
            k = 4'($urandom);
         end else begin
            k = rand_keys[$urandom_range(0, 5)];
         end
         cycle(k);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Downstream consumer of the debounced key scanner. Takes its one-cycle key event code and drives 8 active-low LEDs with a selectable animated pattern. S1 cycles the mode, S2/S3 raise/lower speed, S4 toggles pause. Replaces the scanner's fixed LED decode as the board's user-visible LED stage.

Parameters:
STEP_BASE, 5_000_000, clocks per pattern step at speed 0 (100 ms at 50 MHz); must be divisible by 8
CNT_W, 23, tick counter width; must hold STEP_BASE-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
key_value  input  4  scanner event code: 4'b0001 S1, 4'b0010 S2, 4'b0100 S3, 4'b1000 S4, 4'b1111 none; held 1 clk per press
led  output  8  LED drive, active-low (0 = lit), registered

Behaviour:
- Reset (rst=0, async): mode=RUN_L, speed=0, paused=0, pos=0, dir=up, blink phase=0, tick counter=0, led=8'hFF.
- Key decode, sampled every clk; any code other than the four one-hot values is ignored (no state change):
  S1: mode advances RUN_L -> RUN_R -> BOUNCE -> BLINK -> RUN_L.
  S2: speed+1, saturates at 3. S3: speed-1, saturates at 0.
  S4: paused toggles.
- Step period = STEP_BASE >> speed clocks (speed 0..3 gives 1x, 2x, 4x, 8x rate).
- Tick counter: counts 0..period-1 while not paused. On reaching period-1 it wraps to 0 and issues a 1-clk step.
  While paused, counter and all pattern state hold.
- Reset of pattern state:
  S1 clears counter, pos=0, dir=up, blink phase=0.
  S2/S3 clear the counter only, even when saturated.
  S4 does not touch the counter.
- Step actions:
  RUN_L: pos = pos+1 mod 8.
  RUN_R: pos = pos-1 mod 8.
  BOUNCE: 0,1,..,7,6,..,0,1,...; dir flips to down on reaching 7 and to up on reaching 0; no dwell at ends.
  BLINK: blink phase toggles.
- Simultaneous key event and step in the same clk: key action applies, step is discarded.
- led output:
  RUN_L/RUN_R/BOUNCE: ~(8'b1 << pos).
  BLINK: 8'hFF when phase=0, 8'h00 when phase=1.
- Latency: key event sampled at edge E updates state at E; led reflects it at E+1. The same holds for steps.
- Reset asserted mid-animation returns everything to reset values immediately; first step occurs period clocks after release.

Optional Feature:
Macro SPEED_WRAP_EN.
- Defined: S2 at speed 3 wraps to 0; S3 at speed 0 wraps to 3.
- Not defined: saturating behaviour as above.
- Counter-clear rule unchanged in both cases.

Decomposition:
- Package led_pattern_pkg: key code constants (KEY_S1..KEY_S4, KEY_NONE), 2-bit mode encoding (RUN_L=0, RUN_R=1, BOUNCE=2, BLINK=3), SPEED_MAX=3.
- One sub-module, led_step_timer: holds the tick counter. Inputs: period, enable (=~paused), clear. Output: step pulse.
- Top holds mode/speed/pause regs, pattern regs and the led register.

Test Plan (bench STEP_BASE=16):
- Reset then release, no keys -> led=8'hFF during reset, 8'hFE after first edge; 8'hFD 16 clks later; after 8 steps back to 8'hFE.
- S1 pulse mid-count -> mode=RUN_R, led=8'hFE next clk, then 8'h7F after 16 clks.
- S1 x2 (BOUNCE), observe 16 steps -> pos 0..7..0 with single visits at 7 and 0; one dir flip at 7, one at 0.
- S2 x4 -> speed 3, step every 2 clks; S3 x5 -> speed 0, step every 16 clks.
- SPEED_WRAP_EN build: S2 x4 -> speed 0, step every 16 clks; S3 x1 from speed 0 -> speed 3, step every 2 clks.
- S4 in BLINK -> led frozen for 100 clks; second S4 resumes, toggling every 16 clks.
- Key 4'b0011 and 4'b0000 -> no state change.
- S2 on the same clk as a step -> step suppressed, counter restarts from 0.
- rst asserted mid-BOUNCE -> led=8'hFF immediately (async).
